// File: rtl/piso_ctrl_pkg.sv
// Shared constants and state encoding for the 10:1 serializer feed controller.
package piso_ctrl_pkg;
  localparam int WORD_W    = 10;
  localparam int FRAME_LEN = 10;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEFAULT = 10'b0011111010;
  // Gap value expected on the cycle a strobe arrives.
  localparam logic [3:0] GAP_CHECK = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    RUN     = 2'd1,
    ERROR   = 2'd2
  } feed_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             any_gnt
);
  logic [IW-1:0] idx_c;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx_c   = '0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx_c = IW'((int'(ptr) + k) % N_REQ);
        if (!any_gnt && req[idx_c]) begin
          any_gnt      = 1'b1;
          gnt[idx_c]   = 1'b1;
          gnt_idx      = idx_c;
        end
      end
    end
  end
endmodule

// File: rtl/piso10_1_feed_ctrl.sv
// Round-robin word feed for the 10:1 PISO serializer with frame-cadence checking.
module piso10_1_feed_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int                N_REQ     = 4,
  parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
  input  logic                      CLK_IN,
  input  logic                      RESET_IN,
  input  logic                      ENABLE_IN,
  input  logic                      DATA_USED_IN,
  input  logic [N_REQ-1:0]          REQ_VALID_IN,
  input  logic [WORD_W*N_REQ-1:0]   REQ_DATA_IN,
  output logic [N_REQ-1:0]          REQ_READY_OUT,
  output logic [WORD_W-1:0]         PARALLEL_OUT,
  output logic [$clog2(N_REQ)-1:0]  GRANT_ID_OUT,
  output logic                      IDLE_OUT,
  output logic                      SYNC_ERR_OUT
);
  localparam int IW = $clog2(N_REQ);

  feed_state_t                    state;
  logic [IW-1:0]                  ptr;
  logic [3:0]                     gap;
  logic [N_REQ-1:0][WORD_W-1:0]   req_words;
  logic [N_REQ-1:0]               gnt;
  logic [IW-1:0]                  gnt_idx;
  logic [IW-1:0]                  ptr_nxt;
  logic                           any_gnt;
  logic                           cad_err;
  logic                           load_ok;

  assign req_words = REQ_DATA_IN;

  // A strobe in RUN is only honoured when it lands exactly on the frame boundary.
  assign cad_err = (state == RUN) &&
                   ((DATA_USED_IN && gap != GAP_CHECK) || (!DATA_USED_IN && gap == GAP_CHECK));
  assign load_ok = DATA_USED_IN && !RESET_IN &&
                   ((state == ACQUIRE) || (state == RUN && gap == GAP_CHECK));

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req     (REQ_VALID_IN),
    .ptr     (ptr),
    .en      (load_ok && ENABLE_IN),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign REQ_READY_OUT = gnt;
  assign ptr_nxt = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state        <= ACQUIRE;
      ptr          <= '0;
      gap          <= '0;
      PARALLEL_OUT <= IDLE_WORD;
      IDLE_OUT     <= 1'b1;
      GRANT_ID_OUT <= '0;
      SYNC_ERR_OUT <= 1'b0;
    end else begin
      case (state)
        ACQUIRE, RUN: begin
          if (state == RUN) gap <= DATA_USED_IN ? 4'd0 : (gap == 4'hF ? gap : gap + 4'd1);
          else              gap <= '0;
          if (cad_err) begin
            state        <= ERROR;
            SYNC_ERR_OUT <= 1'b1;
            PARALLEL_OUT <= IDLE_WORD;
            IDLE_OUT     <= 1'b1;
          end else if (DATA_USED_IN) begin
            state <= RUN;
            if (any_gnt) begin
              PARALLEL_OUT <= req_words[gnt_idx];
              GRANT_ID_OUT <= gnt_idx;
              IDLE_OUT     <= 1'b0;
              ptr          <= ptr_nxt;
            end else begin
              PARALLEL_OUT <= IDLE_WORD;
              IDLE_OUT     <= 1'b1;
            end
          end
        end
        ERROR: begin
          PARALLEL_OUT <= IDLE_WORD;
          IDLE_OUT     <= 1'b1;
        end
        default: state <= ACQUIRE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso10_1_feed_ctrl.sv
// Directed bench for piso10_1_feed_ctrl with a small behavioural serializer on the output.
module tb_piso10_1_feed_ctrl;
  logic        CLK_IN = 1'b0;
  logic        RESET_IN;
  logic        ENABLE_IN;
  logic        DATA_USED_IN;
  logic [3:0]  REQ_VALID_IN;
  logic [39:0] REQ_DATA_IN;
  logic [3:0]  REQ_READY_OUT;
  logic [9:0]  PARALLEL_OUT;
  logic [1:0]  GRANT_ID_OUT;
  logic        IDLE_OUT;
  logic        SYNC_ERR_OUT;

  logic [9:0]  ser_sh;
  logic [9:0]  ser_word;
  int          n_tests = 0;
  int          n_fail  = 0;

  piso10_1_feed_ctrl #(.N_REQ(4), .IDLE_WORD(10'h0FA)) dut (
    .CLK_IN        (CLK_IN),
    .RESET_IN      (RESET_IN),
    .ENABLE_IN     (ENABLE_IN),
    .DATA_USED_IN  (DATA_USED_IN),
    .REQ_VALID_IN  (REQ_VALID_IN),
    .REQ_DATA_IN   (REQ_DATA_IN),
    .REQ_READY_OUT (REQ_READY_OUT),
    .PARALLEL_OUT  (PARALLEL_OUT),
    .GRANT_ID_OUT  (GRANT_ID_OUT),
    .IDLE_OUT      (IDLE_OUT),
    .SYNC_ERR_OUT  (SYNC_ERR_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Serializer: capture on strobe, shift LSB first otherwise.
  always @(posedge CLK_IN) begin
    if (DATA_USED_IN) ser_sh <= PARALLEL_OUT;
    else              ser_sh <= {1'b0, ser_sh[9:1]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n clock edges; strobe is dropped after each edge.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_IN);
      #1;
      DATA_USED_IN = 1'b0;
    end
  endtask

  task automatic strobe();
    DATA_USED_IN = 1'b1;
    #1;
  endtask

  task automatic grant_frame(input int k, input logic [9:0] w);
    strobe();
    chk("rdy_grant", 32'(REQ_READY_OUT), 32'(4'b1 << k));
    adv(1);
    chk("rdy_pulse", 32'(REQ_READY_OUT), 32'h0);
    chk("word", 32'(PARALLEL_OUT), 32'(w));
    chk("gid", 32'(GRANT_ID_OUT), 32'(k));
    chk("idle_lo", 32'(IDLE_OUT), 32'h0);
    adv(9);
  endtask

  initial begin
    RESET_IN     = 1'b1;
    ENABLE_IN    = 1'b1;
    DATA_USED_IN = 1'b0;
    REQ_VALID_IN = 4'b0000;
    REQ_DATA_IN  = {10'h008, 10'h004, 10'h002, 10'h001};
    adv(2);
    chk("rst_par", 32'(PARALLEL_OUT), 32'h0FA);
    chk("rst_idle", 32'(IDLE_OUT), 32'h1);
    chk("rst_gid", 32'(GRANT_ID_OUT), 32'h0);
    chk("rst_rdy", 32'(REQ_READY_OUT), 32'h0);
    chk("rst_err", 32'(SYNC_ERR_OUT), 32'h0);
    RESET_IN = 1'b0;
    adv(1);

    // Idle stream: no requesters, lock and run 10 frames.
    strobe();
    chk("idle_rdy", 32'(REQ_READY_OUT), 32'h0);
    adv(10);
    for (int f = 0; f < 10; f++) begin
      strobe();
      adv(1);
      for (int j = 0; j < 10; j++) begin
        ser_word[j] = ser_sh[0];
        if (j < 9) adv(1);
      end
      chk("idle_ser", 32'(ser_word), 32'h0FA);
      chk("idle_par", 32'(PARALLEL_OUT), 32'h0FA);
      chk("idle_flag", 32'(IDLE_OUT), 32'h1);
      chk("idle_err", 32'(SYNC_ERR_OUT), 32'h0);
    end

    // All four valid: strict rotation.
    REQ_VALID_IN = 4'b1111;
    grant_frame(0, 10'h001);
    grant_frame(1, 10'h002);
    grant_frame(2, 10'h004);
    grant_frame(3, 10'h008);
    grant_frame(0, 10'h001);

    // Only requester 2, then requester 0 raised mid-frame: pointer wraps.
    REQ_VALID_IN = 4'b0100;
    strobe();
    chk("r2_rdy", 32'(REQ_READY_OUT), 32'h4);
    adv(1);
    chk("r2_word", 32'(PARALLEL_OUT), 32'h004);
    chk("r2_gid", 32'(GRANT_ID_OUT), 32'h2);
    REQ_VALID_IN = 4'b0000;
    adv(4);
    REQ_VALID_IN = 4'b0001;
    #1;
    chk("mid_rdy", 32'(REQ_READY_OUT), 32'h0);
    adv(5);
    grant_frame(0, 10'h001);

    // Enable low for one load: idle frame, pointer held.
    REQ_VALID_IN = 4'b1111;
    ENABLE_IN    = 1'b0;
    strobe();
    chk("dis_rdy", 32'(REQ_READY_OUT), 32'h0);
    adv(1);
    chk("dis_par", 32'(PARALLEL_OUT), 32'h0FA);
    chk("dis_idle", 32'(IDLE_OUT), 32'h1);
    chk("dis_gid", 32'(GRANT_ID_OUT), 32'h0);
    adv(3);
    ENABLE_IN = 1'b1;
    adv(1);
    chk("en_mid_par", 32'(PARALLEL_OUT), 32'h0FA);
    adv(5);
    strobe();
    chk("res_rdy", 32'(REQ_READY_OUT), 32'h2);
    adv(1);
    chk("res_word", 32'(PARALLEL_OUT), 32'h002);
    chk("res_gid", 32'(GRANT_ID_OUT), 32'h1);

    // Early strobe at gap=5.
    adv(5);
    strobe();
    chk("early_rdy", 32'(REQ_READY_OUT), 32'h0);
    adv(1);
    chk("early_err", 32'(SYNC_ERR_OUT), 32'h1);
    chk("early_par", 32'(PARALLEL_OUT), 32'h0FA);
    chk("early_idle", 32'(IDLE_OUT), 32'h1);
    adv(8);
    strobe();
    chk("err_rdy", 32'(REQ_READY_OUT), 32'h0);
    adv(1);
    chk("err_sticky", 32'(SYNC_ERR_OUT), 32'h1);

    // Reset mid-frame in ERROR, strobe held high during reset.
    adv(3);
    RESET_IN     = 1'b1;
    DATA_USED_IN = 1'b1;
    #1;
    chk("rst2_rdy_during", 32'(REQ_READY_OUT), 32'h0);
    adv(1);
    chk("rst2_err", 32'(SYNC_ERR_OUT), 32'h0);
    chk("rst2_par", 32'(PARALLEL_OUT), 32'h0FA);
    chk("rst2_idle", 32'(IDLE_OUT), 32'h1);
    chk("rst2_gid", 32'(GRANT_ID_OUT), 32'h0);
    chk("rst2_rdy", 32'(REQ_READY_OUT), 32'h0);
    RESET_IN = 1'b0;
    adv(2);
    grant_frame(0, 10'h001);

    // Missing strobe at gap=9.
    chk("miss_rdy", 32'(REQ_READY_OUT), 32'h0);
    adv(1);
    chk("miss_err", 32'(SYNC_ERR_OUT), 32'h1);
    chk("miss_par", 32'(PARALLEL_OUT), 32'h0FA);
    strobe();
    chk("miss_rdy2", 32'(REQ_READY_OUT), 32'h0);
    adv(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/piso10_1_feed_ctrl.md
# piso10_1_feed_ctrl

Round-robin feed controller for the 10:1 parallel-in/serial-out serializer. It shares the serializer between N_REQ word sources and holds one 10-bit word on the serializer's parallel input. On each consume strobe from the serializer it hands over the next granted word, or an idle comma when no source is ready or feed is disabled. It also watches the 10-cycle frame cadence and latches an error if the serializer loses phase.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- IDLE_WORD, 10'b0011111010: word loaded when nothing is granted (K28.5, RD−).

Ports:
- CLK_IN, input, 1: single clock, shared with the serializer.
- RESET_IN, input, 1: reset, synchronous, active-high.
- ENABLE_IN, input, 1: when low, only IDLE_WORD is loaded and no grants are issued.
- DATA_USED_IN, input, 1: serializer consume strobe, one cycle per 10-cycle frame.
- REQ_VALID_IN, input, N_REQ: per-requester word available.
- REQ_DATA_IN, input, 10*N_REQ: requester i word is bits [10i+9:10i].
- REQ_READY_OUT, output, N_REQ: one-hot accept pulse, combinational.
- PARALLEL_OUT, output, 10: held word, wired to the serializer parallel input.
- GRANT_ID_OUT, output, clog2(N_REQ): index of the last granted requester.
- IDLE_OUT, output, 1: the held word is IDLE_WORD inserted by the controller.
- SYNC_ERR_OUT, output, 1: sticky frame-cadence error.

## Operation
- States:
  - ACQUIRE (reset state): waiting for the first DATA_USED_IN.
  - RUN: normal operation.
  - ERROR: terminal until RESET_IN.
- Reset values:
  - PARALLEL_OUT=IDLE_WORD, IDLE_OUT=1.
  - GRANT_ID_OUT=0, REQ_READY_OUT=0, SYNC_ERR_OUT=0.
  - Round-robin pointer=0, gap counter=0.
- Load event: DATA_USED_IN=1 while in ACQUIRE or RUN.
  - If ENABLE_IN=1 and any REQ_VALID_IN is set, grant the first valid index at or after the pointer, searching upward modulo N_REQ.
  - On a grant, the winner's REQ_READY_OUT=1 in that same cycle. Next cycle: PARALLEL_OUT=winner word, GRANT_ID_OUT=winner, IDLE_OUT=0, pointer=(winner+1) mod N_REQ.
  - With no grant: PARALLEL_OUT=IDLE_WORD, IDLE_OUT=1; pointer and GRANT_ID_OUT are unchanged.
- ACQUIRE→RUN on the first DATA_USED_IN. That cycle is a normal load event.
- Gap counter (4 bits):
  - Clears to 0 on a DATA_USED_IN cycle; otherwise increments, saturating at 15.
  - Active only in RUN.
- RUN→ERROR on either condition:
  - DATA_USED_IN=1 while gap≠9 (strobe too early).
  - gap=9 and DATA_USED_IN=0 (strobe missing).
  - In that cycle: no grant, REQ_READY_OUT=0.
- ERROR behaviour:
  - SYNC_ERR_OUT=1 from the next cycle.
  - PARALLEL_OUT=IDLE_WORD, IDLE_OUT=1, REQ_READY_OUT held 0, DATA_USED_IN ignored.
- REQ_READY_OUT is never asserted outside a load event, and never to a requester whose REQ_VALID_IN is 0.
- Requesters must hold VALID and DATA stable until READY; a requester may drop VALID without penalty.

## Timing
- After RESET_IN deasserts with the serializer reset together, the first DATA_USED_IN arrives in cycle 2. From then on strobes are exactly 10 cycles apart.
- PARALLEL_OUT changes only in the cycle after DATA_USED_IN. The serializer captures 9 cycles later, so the word is stable for the whole capture window.
- Accept-to-serial latency: the word is captured at the next serializer load. Its LSB appears on SERIAL_OUT one cycle after capture.
- Each requester gets at most one word per frame. Worst-case wait with all N_REQ valid is N_REQ frames.
- ENABLE_IN is sampled only on load cycles. Toggling it mid-frame has no effect on the held word.
- RESET_IN has priority over every other input in all states, including mid-frame and in ERROR.

## Structure
- Package piso_ctrl_pkg holds:
  - WORD_W=10, FRAME_LEN=10, IDLE_WORD_DEFAULT.
  - The state enum {ACQUIRE, RUN, ERROR}.
  - The gap-check constant FRAME_LEN-1.
- Sub-module rr_arbiter: parameterised round-robin arbiter.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant, grant index, any-grant.
  - Purely combinational.
- The top level holds the FSM, held-word register, pointer and gap counter.

## Test plan
- Reset, then ENABLE_IN=1 with REQ_VALID_IN=4'b0000, serializer attached.
  - PARALLEL_OUT stays 10'h0FA with IDLE_OUT=1.
  - SERIAL_OUT repeats 0,1,0,1,1,1,1,1,0,0.
  - SYNC_ERR_OUT stays 0 for 100 cycles.
- All four requesters valid with words 10'h001/002/004/008.
  - Grants run 0,1,2,3,0, one per DATA_USED_IN.
  - Each READY is a single-cycle pulse coincident with the strobe.
  - PARALLEL_OUT matches the granted word in the following cycle.
- Only requester 2 valid; requester 0 asserts valid mid-frame.
  - Requester 2 is granted first, then requester 0 at the next strobe. The pointer wrap is confirmed.
- ENABLE_IN low for one load cycle with requesters valid.
  - That frame carries IDLE_WORD, with no READY pulse and GRANT_ID_OUT unchanged.
  - The next frame resumes at the same pointer.
- Forced cadence faults:
  - DATA_USED_IN injected at gap=5 → SYNC_ERR_OUT=1 next cycle, and READY stays 0 thereafter.
  - Separately, a strobe suppressed at gap=9 → the same response.
- RESET_IN pulsed mid-frame while in ERROR.
  - Next cycle shows all outputs at reset values and state ACQUIRE.
  - Relock on the strobe in cycle 2 after release.
